mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32I pipeline; sits directly downstream of the execute stage and upstream of write-back.
- Latches the execute-to-memory bus and waits a configurable DRAM read latency for loads.
- Aligns and sign/zero-extends load data, then selects the final register-file write data.
- Drives the memory-to-write-back bus and a bypass bus back to decode; uses the same valid/allow_in pipeline handshake as the other stages.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_load_ext.sv | 32 +++
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline widths, write-back select and load-extension encodings,
// plus the packed layout of the execute-to-memory bus.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_BUS_WIDTH = 140;
  localparam int unsigned MEM_TO_WB_BUS_WIDTH = 38;
  localparam int unsigned MEM_TO_ID_BUS_WIDTH = 39;
  localparam int unsigned MEM_EXT_OP_WIDTH    = 3;
  localparam int unsigned WB_SEL_WIDTH        = 3;

  typedef enum logic [MEM_EXT_OP_WIDTH-1:0] {
    MEM_EXT_NONE = 3'd0,
    MEM_EXT_LB   = 3'd1,
    MEM_EXT_LBU  = 3'd2,
    MEM_EXT_LH   = 3'd3,
    MEM_EXT_LHU  = 3'd4,
    MEM_EXT_LW   = 3'd5
  } mem_ext_e;

  typedef enum logic [WB_SEL_WIDTH-1:0] {
    WB_ALU = 3'd0,
    WB_EXT = 3'd1,
    WB_PC4 = 3'd2,
    WB_MEM = 3'd3,
    WB_CSR = 3'd4
  } wb_sel_e;

  // Field order matches the bus, MSB first.
  typedef struct packed {
    logic [MEM_EXT_OP_WIDTH-1:0] mem_ext_op;
    logic                        rf_we;
    logic [WB_SEL_WIDTH-1:0]     rf_wsel;
    logic [31:0]                 pc4;
    logic [31:0]                 ext;
    logic [4:0]                  wb_reg;
    logic [31:0]                 alu_c;
    logic [31:0]                 csr_rdata;
  } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment and sign/zero extension from a word-aligned read.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [MEM_EXT_OP_WIDTH-1:0] mem_ext_op,
  input  logic [1:0]                  offset,
  input  logic [31:0]                 dram_rdata,
  output logic [31:0]                 result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_shift = dram_rdata >> {offset, 3'b000};
    half_shift = dram_rdata >> {offset[1], 4'b0000};
    byte_val   = byte_shift[7:0];
    half_val   = half_shift[15:0];
    result     = '0;
    case (mem_ext_op)
      MEM_EXT_LB:  result = {{24{byte_val[7]}}, byte_val};
      MEM_EXT_LBU: result = {24'd0, byte_val};
      MEM_EXT_LH:  result = {{16{half_val[15]}}, half_val};
      MEM_EXT_LHU: result = {16'd0, half_val};
      MEM_EXT_LW:  result = dram_rdata;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: latches the EX bus, waits DRAM_RD_LAT cycles for loads,
// extends load data and drives the WB and decode-bypass buses. Option: MEM_MISALIGN_EXC_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DRAM_RD_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [EX_TO_MEM_BUS_WIDTH-1:0] ex_to_mem_bus,
  input  logic                           ex_to_mem_valid,
  input  logic                           wb_allow_in,
  input  logic [31:0]                    dram_rdata,
  output logic                           mem_allow_in,
  output logic                           mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WIDTH-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_BUS_WIDTH-1:0] mem_to_id_bus
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic                           misalign_exc,
  output logic [31:0]                    misalign_addr
`endif
);

  localparam logic [2:0] RD_LAT = DRAM_RD_LAT[2:0];

  ex_to_mem_t  mem_regs;
  logic        mem_valid;
  logic [2:0]  wait_cnt;
  logic        is_load;
  logic        ready_go;
  logic        accept;
  logic        wb_we;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign is_load         = (mem_regs.rf_wsel == WB_MEM);
  assign ready_go        = !is_load || (wait_cnt == RD_LAT);
  assign mem_allow_in    = !mem_valid || (ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid && ready_go;
  assign accept          = mem_allow_in && ex_to_mem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_regs  <= '0;
      wait_cnt  <= '0;
    end else begin
      if (mem_allow_in) begin
        mem_valid <= ex_to_mem_valid;
      end
      if (accept) begin
        mem_regs <= ex_to_mem_bus;
        wait_cnt <= '0;
      end else if (mem_valid && is_load && (wait_cnt < RD_LAT)) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

  load_ext u_load_ext (
    .mem_ext_op (mem_regs.mem_ext_op),
    .offset     (mem_regs.alu_c[1:0]),
    .dram_rdata (dram_rdata),
    .result     (load_data)
  );

  always_comb begin
    rf_wdata = '0;
    case (mem_regs.rf_wsel)
      WB_ALU:  rf_wdata = mem_regs.alu_c;
      WB_EXT:  rf_wdata = mem_regs.ext;
      WB_PC4:  rf_wdata = mem_regs.pc4;
      WB_MEM:  rf_wdata = load_data;
      WB_CSR:  rf_wdata = mem_regs.csr_rdata;
      default: rf_wdata = '0;
    endcase
  end

`ifdef MEM_MISALIGN_EXC_EN
  logic misaligned;
  logic exc_seen;

  assign misaligned = is_load &&
                      ((((mem_regs.mem_ext_op == MEM_EXT_LH) || (mem_regs.mem_ext_op == MEM_EXT_LHU))
                        && mem_regs.alu_c[0]) ||
                       ((mem_regs.mem_ext_op == MEM_EXT_LW) && (mem_regs.alu_c[1:0] != 2'b00)));

  // exc_seen keeps the exception to a single pulse while WB stalls a ready load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_seen <= 1'b0;
    end else if (accept) begin
      exc_seen <= 1'b0;
    end else if (mem_valid && ready_go) begin
      exc_seen <= 1'b1;
    end
  end

  assign misalign_exc  = mem_valid && ready_go && misaligned && !exc_seen;
  assign misalign_addr = mem_regs.alu_c;
  assign wb_we         = mem_valid && mem_regs.rf_we && !misaligned;
`else
  assign wb_we         = mem_valid && mem_regs.rf_we;
`endif

  assign mem_to_wb_bus = {wb_we, mem_regs.wb_reg, rf_wdata};
  // A waiting load exports rf_we = 0 so decode sees mem_valid && !rf_we and stalls.
  assign mem_to_id_bus = {mem_valid, mem_regs.rf_we && !(mem_valid && !ready_go),
                          mem_regs.wb_reg, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random instructions
// checked against an arithmetic reference model of the stage's rules.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned LAT = 1;

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic [2:0]  wsel;
    logic [31:0] pc4;
    logic [31:0] ext;
    logic [4:0]  rg;
    logic [31:0] aluc;
    logic [31:0] csr;
  } instr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [139:0] ex_bus;
  logic         ex_valid;
  logic         wb_allow;
  logic [31:0]  rdata;
  logic         allow_in;
  logic         to_wb_valid;
  logic [37:0]  wb_bus;
  logic [38:0]  id_bus;
`ifdef MEM_MISALIGN_EXC_EN
  logic         mexc;
  logic [31:0]  maddr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.DRAM_RD_LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_to_mem_bus   (ex_bus),
    .ex_to_mem_valid (ex_valid),
    .wb_allow_in     (wb_allow),
    .dram_rdata      (rdata),
    .mem_allow_in    (allow_in),
    .mem_to_wb_valid (to_wb_valid),
    .mem_to_wb_bus   (wb_bus),
    .mem_to_id_bus   (id_bus)
`ifdef MEM_MISALIGN_EXC_EN
    ,
    .misalign_exc    (mexc),
    .misalign_addr   (maddr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] make_bus(input instr_t i);
    return {i.op, i.we, i.wsel, i.pc4, i.ext, i.rg, i.aluc, i.csr};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w,
                                             input logic [31:0] addr);
    longint unsigned word, b, h;
    int unsigned off;
    off  = addr % 4;
    word = w;
    b = (word / (64'd1 << (8 * off))) % 256;
    h = (word / (64'd1 << (16 * (off / 2)))) % 65536;
    case (op)
      MEM_EXT_LB:  return (b < 128)   ? 32'(b) : 32'(b + 64'hFFFF_FF00);
      MEM_EXT_LBU: return 32'(b);
      MEM_EXT_LH:  return (h < 32768) ? 32'(h) : 32'(h + 64'hFFFF_0000);
      MEM_EXT_LHU: return 32'(h);
      MEM_EXT_LW:  return w;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input instr_t i, input logic [31:0] w);
    case (i.wsel)
      WB_ALU:  return i.aluc;
      WB_EXT:  return i.ext;
      WB_PC4:  return i.pc4;
      WB_MEM:  return model_load(i.op, w, i.aluc);
      WB_CSR:  return i.csr;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_misalign(input instr_t i);
`ifdef MEM_MISALIGN_EXC_EN
    int unsigned off;
    off = i.aluc % 4;
    if (i.wsel != WB_MEM) return 1'b0;
    if ((i.op == MEM_EXT_LH || i.op == MEM_EXT_LHU) && (off % 2 == 1)) return 1'b1;
    if (i.op == MEM_EXT_LW && off != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.op   = 3'($urandom_range(0, 7));
    i.we   = 1'($urandom_range(0, 1));
    i.wsel = 3'($urandom_range(0, 5));
    i.pc4  = $urandom;
    i.ext  = $urandom;
    i.rg   = 5'($urandom_range(0, 31));
    i.aluc = $urandom;
    i.csr  = $urandom;
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through an empty stage with WB always accepting.
  task automatic run_one(input string tag, input instr_t i, input logic [31:0] w,
                         input logic [31:0] exp_data);
    int n;
    int lat_exp;
    logic mis;
    lat_exp  = (i.wsel == WB_MEM) ? int'(LAT) : 0;
    mis      = model_misalign(i);
    ex_bus   = make_bus(i);
    ex_valid = 1'b1;
    wb_allow = 1'b1;
    rdata    = w;
    #1;
    check({tag, ".allow_empty"}, allow_in, 1);
    tick();
    ex_valid = 1'b0;
    ex_bus   = 140'({$urandom, $urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (to_wb_valid !== 1'b1 && n < 10) begin
      check({tag, ".id_wait"}, id_bus, {1'b1, 1'b0, i.rg, exp_data});
      check({tag, ".allow_wait"}, allow_in, 0);
`ifdef MEM_MISALIGN_EXC_EN
      check({tag, ".exc_wait"}, mexc, 0);
`endif
      tick();
      n++;
    end
    check({tag, ".latency"}, n, lat_exp);
    check({tag, ".wb_bus"}, wb_bus, {i.we && !mis, i.rg, exp_data});
    check({tag, ".id_bus"}, id_bus, {1'b1, i.we, i.rg, exp_data});
`ifdef MEM_MISALIGN_EXC_EN
    check({tag, ".exc"}, mexc, mis);
    check({tag, ".exc_addr"}, maddr, i.aluc);
`endif
    tick();
    check({tag, ".drained"}, to_wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    instr_t a, b;
    rst_n    = 1'b0;
    ex_bus   = '0;
    ex_valid = 1'b0;
    wb_allow = 1'b1;
    rdata    = '0;
    #12;
    check("reset.to_wb_valid", to_wb_valid, 0);
    check("reset.allow_in", allow_in, 1);
    check("reset.wb_bus", wb_bus, 0);
    check("reset.id_bus", id_bus, 0);
    rst_n = 1'b1;
    tick();

    // LB at byte 3
    a = '{op: MEM_EXT_LB, we: 1'b1, wsel: WB_MEM, pc4: 32'h4, ext: 32'h0, rg: 5'd7,
          aluc: 32'h0000_0103, csr: 32'h0};
    run_one("lb", a, 32'h8011_2233, 32'hFFFF_FF80);
    a.op = MEM_EXT_LHU; a.aluc = 32'h0000_2002; a.rg = 5'd8;
    run_one("lhu", a, 32'h9ABC_1234, 32'h0000_9ABC);
    a.op = MEM_EXT_LH;
    run_one("lh", a, 32'h9ABC_1234, 32'hFFFF_9ABC);
    a = '{op: MEM_EXT_NONE, we: 1'b1, wsel: WB_ALU, pc4: 32'h8, ext: 32'h55, rg: 5'd3,
          aluc: 32'h0000_1234, csr: 32'h77};
    run_one("alu", a, 32'hFFFF_FFFF, 32'h0000_1234);
    a = '{op: MEM_EXT_LW, we: 1'b1, wsel: WB_MEM, pc4: 32'h0, ext: 32'h0, rg: 5'd9,
          aluc: 32'h0000_0102, csr: 32'h0};
    run_one("lw_mis", a, 32'h1357_9BDF, 32'h1357_9BDF);

    // WB stall: a ready load must hold; a younger instruction waits outside
    a = '{op: MEM_EXT_LBU, we: 1'b1, wsel: WB_MEM, pc4: 32'h0, ext: 32'h0, rg: 5'd4,
          aluc: 32'h0000_0001, csr: 32'h0};
    b = '{op: MEM_EXT_NONE, we: 1'b1, wsel: WB_ALU, pc4: 32'h0, ext: 32'h0, rg: 5'd5,
          aluc: 32'h0000_5678, csr: 32'h0};
    rdata = 32'h0000_C300;
    ex_bus = make_bus(a); ex_valid = 1'b1; wb_allow = 1'b0;
    tick();
    ex_bus = make_bus(b);
    check("stall.wait_valid", to_wb_valid, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("stall.allow_in", allow_in, 0);
      check("stall.valid", to_wb_valid, 1);
      check("stall.wb_bus", wb_bus, {1'b1, 5'd4, 32'h0000_00C3});
      check("stall.id_bus", id_bus, {1'b1, 1'b1, 5'd4, 32'h0000_00C3});
      tick();
    end
    wb_allow = 1'b1;
    #1;
    check("stall.release_allow", allow_in, 1);
    tick();
    ex_valid = 1'b0;
    check("stall.next_valid", to_wb_valid, 1);
    check("stall.next_wb_bus", wb_bus, {1'b1, 5'd5, 32'h0000_5678});
    tick();
    check("stall.drained", to_wb_valid, 0);

    // Back-to-back loads: the second restarts its wait
    a = '{op: MEM_EXT_LW, we: 1'b1, wsel: WB_MEM, pc4: 32'h0, ext: 32'h0, rg: 5'd10,
          aluc: 32'h0000_0040, csr: 32'h0};
    b = '{op: MEM_EXT_LB, we: 1'b1, wsel: WB_MEM, pc4: 32'h0, ext: 32'h0, rg: 5'd11,
          aluc: 32'h0000_0044, csr: 32'h0};
    rdata = 32'hA5A5_0001;
    ex_bus = make_bus(a); ex_valid = 1'b1;
    tick();
    ex_bus = make_bus(b);
    check("b2b.a_wait_id", id_bus, {1'b1, 1'b0, 5'd10, 32'hA5A5_0001});
    tick();
    check("b2b.a_valid", to_wb_valid, 1);
    check("b2b.a_wb_bus", wb_bus, {1'b1, 5'd10, 32'hA5A5_0001});
    check("b2b.a_allow", allow_in, 1);
    rdata = 32'h0000_00FE;
    tick();
    ex_valid = 1'b0;
    check("b2b.b_restart", to_wb_valid, 0);
    check("b2b.b_wait_id", id_bus, {1'b1, 1'b0, 5'd11, 32'hFFFF_FFFE});
    tick();
    check("b2b.b_valid", to_wb_valid, 1);
    check("b2b.b_wb_bus", wb_bus, {1'b1, 5'd11, 32'hFFFF_FFFE});
    tick();

    // Asynchronous reset while a load waits
    a = '{op: MEM_EXT_LW, we: 1'b1, wsel: WB_MEM, pc4: 32'h0, ext: 32'h0, rg: 5'd12,
          aluc: 32'h0000_0100, csr: 32'h0};
    ex_bus = make_bus(a); ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.to_wb_valid", to_wb_valid, 0);
    check("rst_mid.id_bus", id_bus, 0);
    check("rst_mid.wb_bus", wb_bus, 0);
    #3;
    rst_n = 1'b1;
    tick();
    run_one("rst_lw", a, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Random instructions against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] w;
      a = rand_instr();
      w = $urandom;
      run_one("rand", a, w, model_wdata(a, w));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
